// File: rtl/posit_csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : posit_csr_pkg
//  Description : Shared definitions for the posit coprocessor CSR slave:
//                register word addresses, CTRL/STATUS bit positions,
//                the ID constant and the sequencing FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package posit_csr_pkg;

    // Register word addresses on the Avalon-MM slave
    localparam logic [2:0] c_ADDR_NUM1    = 3'd0;
    localparam logic [2:0] c_ADDR_NUM2    = 3'd1;
    localparam logic [2:0] c_ADDR_CTRL    = 3'd2;
    localparam logic [2:0] c_ADDR_STATUS  = 3'd3;
    localparam logic [2:0] c_ADDR_RESULT  = 3'd4;
    localparam logic [2:0] c_ADDR_CYCLES  = 3'd5;
    localparam logic [2:0] c_ADDR_TIMEOUT = 3'd6;
    localparam logic [2:0] c_ADDR_ID      = 3'd7;

    // CTRL bit positions
    localparam int c_CTRL_START  = 0;
    localparam int c_CTRL_IRQ_EN = 1;
    localparam int c_CTRL_CLR    = 2;

    // STATUS bit positions
    localparam int c_STAT_BUSY      = 0;
    localparam int c_STAT_DONE      = 1;
    localparam int c_STAT_TIMEOUT   = 2;
    localparam int c_STAT_OVF       = 3;
    localparam int c_STAT_OPCNT_LSB = 8;

    localparam logic [31:0] c_ID_VALUE = 32'h9051_7001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/posit_csr_regs.sv
`default_nettype none
// ============================================================================
//  Module      : posit_csr_regs
//  Description : Address decode and read multiplexer of the posit CSR slave.
//                Purely combinational; storage lives in posit_csr_slave.
//  Ports       : i_address/i_read/i_write  - Avalon-MM command
//                i_* status/register values - current register contents
//                o_wr_*                     - qualified write strobes
//                o_rd_result                - RESULT read strobe
//                o_rdata                    - read data for the addressed word
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_csr_regs
    import posit_csr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        i_address,
    input  logic              i_read,
    input  logic              i_write,
    input  logic              i_busy,
    input  logic              i_done,
    input  logic              i_timeout,
    input  logic              i_ovf,
    input  logic              i_irq_en,
    input  logic [7:0]        i_op_count,
    input  logic [DATA_W-1:0] i_num1,
    input  logic [DATA_W-1:0] i_num2,
    input  logic [DATA_W-1:0] i_result,
    input  logic [15:0]       i_cycles,
    input  logic [15:0]       i_tmo,
    output logic              o_wr_num1,
    output logic              o_wr_num2,
    output logic              o_wr_ctrl,
    output logic              o_wr_tmo,
    output logic              o_rd_result,
    output logic [DATA_W-1:0] o_rdata
);

    // A read and a write in the same cycle: the read is served, the write dropped
    logic w_wr;
    assign w_wr = i_write & ~i_read;

    assign o_wr_num1   = w_wr && (i_address == c_ADDR_NUM1);
    assign o_wr_num2   = w_wr && (i_address == c_ADDR_NUM2);
    assign o_wr_ctrl   = w_wr && (i_address == c_ADDR_CTRL);
    assign o_wr_tmo    = w_wr && (i_address == c_ADDR_TIMEOUT);
    assign o_rd_result = i_read && (i_address == c_ADDR_RESULT);

    always_comb begin
        o_rdata = '0;
        case (i_address)
            c_ADDR_NUM1:    o_rdata = i_num1;
            c_ADDR_NUM2:    o_rdata = i_num2;
            c_ADDR_CTRL:    o_rdata[c_CTRL_IRQ_EN] = i_irq_en;
            c_ADDR_STATUS: begin
                o_rdata[c_STAT_BUSY]    = i_busy;
                o_rdata[c_STAT_DONE]    = i_done;
                o_rdata[c_STAT_TIMEOUT] = i_timeout;
                o_rdata[c_STAT_OVF]     = i_ovf;
                o_rdata[c_STAT_OPCNT_LSB +: 8] = i_op_count;
            end
            c_ADDR_RESULT:  o_rdata = i_result;
            c_ADDR_CYCLES:  o_rdata[15:0] = i_cycles;
            c_ADDR_TIMEOUT: o_rdata[15:0] = i_tmo;
            default:        o_rdata = DATA_W'(c_ID_VALUE);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/posit_csr_slave.sv
`default_nettype none
// ============================================================================
//  Module      : posit_csr_slave
//  Description : Avalon-MM CSR slave that feeds two operands to a posit core,
//                waits for its result with a cycle counter / timeout, and
//                raises an optional completion interrupt. DATA_W >= 16.
//  Ports       : clock, reset_n          - clock, async active-low reset
//                avs_*                   - Avalon-MM slave (read latency 1)
//                core_num1/2, core_valid - operand request to the core
//                core_ready              - core accepts the request
//                core_result(_valid)     - result from the core
//                irq                     - done & irq_en, registered
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_csr_slave
    import posit_csr_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter logic [15:0] TMO_DEFAULT = 16'h0400
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    output logic [DATA_W-1:0] core_num1,
    output logic [DATA_W-1:0] core_num2,
    output logic              core_valid,
    input  logic              core_ready,
    input  logic [DATA_W-1:0] core_result,
    input  logic              core_result_valid,
    output logic              irq
);

    state_t            r_state, w_state_next;
    logic [DATA_W-1:0] r_num1, r_num2, r_result;
    logic [15:0]       r_cycles, r_tmo, r_cnt;
    logic [7:0]        r_op_count;
    logic              r_irq_en, r_done, r_timeout, r_ovf;

    logic              w_wr_num1, w_wr_num2, w_wr_ctrl, w_wr_tmo, w_rd_result;
    logic [DATA_W-1:0] w_rdata;
    logic              w_busy, w_start, w_start_ok, w_clr;
    logic              w_complete, w_abort, w_tmo_hit;
    logic [15:0]       w_cnt_next;

    posit_csr_regs #(.DATA_W(DATA_W)) u_regs (
        .i_address   (avs_address),
        .i_read      (avs_read),
        .i_write     (avs_write),
        .i_busy      (w_busy),
        .i_done      (r_done),
        .i_timeout   (r_timeout),
        .i_ovf       (r_ovf),
        .i_irq_en    (r_irq_en),
        .i_op_count  (r_op_count),
        .i_num1      (r_num1),
        .i_num2      (r_num2),
        .i_result    (r_result),
        .i_cycles    (r_cycles),
        .i_tmo       (r_tmo),
        .o_wr_num1   (w_wr_num1),
        .o_wr_num2   (w_wr_num2),
        .o_wr_ctrl   (w_wr_ctrl),
        .o_wr_tmo    (w_wr_tmo),
        .o_rd_result (w_rd_result),
        .o_rdata     (w_rdata)
    );

    assign w_busy     = (r_state != IDLE);
    assign w_start    = w_wr_ctrl & avs_writedata[c_CTRL_START];
    assign w_start_ok = w_start & ~w_busy;
    assign w_clr      = w_wr_ctrl & avs_writedata[c_CTRL_CLR];

    // w_cnt_next counts the current busy cycle as well, so CYCLES reports the
    // full number of cycles spent in ISSUE+WAIT including the completion cycle,
    // and a TIMEOUT of N aborts at the end of the N-th busy cycle.
    assign w_cnt_next = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_tmo_hit  = (r_tmo != 16'd0) && (w_cnt_next == r_tmo);

    always_comb begin
        w_state_next = r_state;
        core_valid   = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) w_state_next = ISSUE;
            end
            ISSUE: begin
                core_valid = 1'b1;
                if (w_tmo_hit) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end else if (core_ready) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                // A result arriving on the timeout cycle is still accepted
                if (core_result_valid) begin
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                end else if (w_tmo_hit) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM, operands, counter and result capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_num1     <= '0;
            r_num2     <= '0;
            r_result   <= '0;
            r_cycles   <= '0;
            r_op_count <= '0;
            r_cnt      <= '0;
            r_tmo      <= TMO_DEFAULT;
            r_irq_en   <= 1'b0;
            core_num1  <= '0;
            core_num2  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_wr_num1 && !w_busy) r_num1 <= avs_writedata;
            if (w_wr_num2 && !w_busy) r_num2 <= avs_writedata;
            if (w_wr_tmo)  r_tmo    <= avs_writedata[15:0];
            if (w_wr_ctrl) r_irq_en <= avs_writedata[c_CTRL_IRQ_EN];
            if (w_start_ok) begin
                core_num1 <= r_num1;
                core_num2 <= r_num2;
                r_cnt     <= '0;
            end else if (w_busy) begin
                r_cnt <= w_cnt_next;
            end
            if (w_complete) begin
                r_result   <= core_result;
                r_cycles   <= w_cnt_next;
                r_op_count <= r_op_count + 8'd1;
            end
        end
    end

    // Status flags: a same-cycle set always beats a clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_ovf     <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (w_complete || w_abort)
                r_done <= 1'b1;
            else if (w_clr || w_rd_result || w_start_ok)
                r_done <= 1'b0;

            if (w_abort)
                r_timeout <= 1'b1;
            else if (w_clr || w_start_ok)
                r_timeout <= 1'b0;

            if (w_start && w_busy)
                r_ovf <= 1'b1;
            else if (w_clr)
                r_ovf <= 1'b0;

            irq <= r_done & r_irq_en;
        end
    end

    // Read channel: fixed one-cycle latency, data held until the next read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) avs_readdata <= w_rdata;
        end
    end

endmodule
`default_nettype wire
